// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit common-anode 7-segment display with double-buffered data.
// Optional leading-zero blanking is built when the SEG_LZB_EN macro is defined.
module seg_scan_ctrl #(
   parameter int CLK_DIV   = 50000,
   parameter int BLANK_CYC = 16,
   parameter int DIGITS    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] seg_value,
   input  logic        seg_we,
   input  logic        enable,
   output logic [7:0]  an,
   output logic [7:0]  seg_n,
   output logic        frame_done
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int DW = $clog2(DIGITS);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic [CW-1:0]   cnt_r, cnt_s;
   logic [DW-1:0]   digit_r, digit_s;
   logic [31:0]     pending_r;
   logic [31:0]     display_r, display_s;
   logic [7:0]      an_s;
   logic [7:0]      seg_n_s;
   logic            frame_done_s;

   function automatic logic [7:0] hex_decode(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         4'hF:    seg = 8'h8E;
         default: seg = 8'hFF;
      endcase
      return seg;
   endfunction

   // Digit 0 is never blanked, so an all-zero value still shows a single "0".
   function automatic logic [7:0] digit_seg(input logic [31:0] disp, input logic [DW-1:0] d);
      logic [7:0] seg;
`ifdef SEG_LZB_EN
      seg = ((d != {DW{1'b0}}) && ((disp >> {d, 2'b00}) == 32'd0)) ? 8'hFF
                                                                   : hex_decode(disp[{d, 2'b00} +: 4]);
`else
      seg = hex_decode(disp[{d, 2'b00} +: 4]);
`endif
      return seg;
   endfunction

   // Next-state sequencing; outputs are decoded from the next state so they register with it.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      digit_s      = digit_r;
      display_s    = display_r;
      frame_done_s = 1'b0;
      an_s         = 8'hFF;
      seg_n_s      = 8'hFF;

      if (!enable) begin
         state_s = IDLE;
         cnt_s   = {CW{1'b0}};
         digit_s = {DW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               state_s   = BLANK;
               cnt_s     = {CW{1'b0}};
               digit_s   = {DW{1'b0}};
               display_s = pending_r;
            end
            BLANK: begin
               cnt_s   = cnt_r + 1'b1;
               state_s = (cnt_r == BLANK_LAST) ? SHOW : BLANK;
            end
            SHOW: begin
               if (cnt_r == SLOT_LAST) begin
                  cnt_s   = {CW{1'b0}};
                  state_s = BLANK;
                  if (digit_r == DIGIT_LAST) begin
                     digit_s      = {DW{1'b0}};
                     display_s    = pending_r;
                     frame_done_s = 1'b1;
                  end else begin
                     digit_s = digit_r + 1'b1;
                  end
               end else begin
                  cnt_s = cnt_r + 1'b1;
               end
            end
            default: begin
               state_s = IDLE;
               cnt_s   = {CW{1'b0}};
               digit_s = {DW{1'b0}};
            end
         endcase
      end

      case (state_s)
         BLANK: begin
            an_s    = 8'hFF;
            seg_n_s = digit_seg(display_s, digit_s);
         end
         SHOW: begin
            an_s    = ~(8'h01 << digit_s);
            seg_n_s = digit_seg(display_s, digit_s);
         end
         default: begin
            an_s    = 8'hFF;
            seg_n_s = 8'hFF;
         end
      endcase
   end

   // State, buffers and registered pin outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= {CW{1'b0}};
         digit_r    <= {DW{1'b0}};
         pending_r  <= 32'd0;
         display_r  <= 32'd0;
         an         <= 8'hFF;
         seg_n      <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         digit_r    <= digit_s;
         display_r  <= display_s;
         an         <= an_s;
         seg_n      <= seg_n_s;
         frame_done <= frame_done_s;
         if (seg_we) begin
            pending_r <= seg_value;
         end else begin
            pending_r <= pending_r;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (CLK_DIV=8, BLANK_CYC=2): per-cycle model comparison plus
// hand-computed checkpoints. Define SEG_LZB_EN to build with leading-zero blanking.
module tb_seg_scan_ctrl;

   localparam int CLK_DIV   = 8;
   localparam int BLANK_CYC = 2;
   localparam int FRAME     = 8 * CLK_DIV;
   localparam logic [127:0] DEC = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                   8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] seg_value = 32'd0;
   logic        seg_we = 1'b0;
   logic        enable = 1'b0;
   logic [7:0]  an;
   logic [7:0]  seg_n;
   logic        frame_done;

   int          n_vec = 0;
   int          n_miss = 0;
   bit          chk_en = 1'b0;

   logic [31:0] m_pending = 32'd0;
   logic [31:0] m_display = 32'd0;
   bit          m_run = 1'b0;
   int          m_t = 0;
   logic [7:0]  exp_an = 8'hFF;
   logic [7:0]  exp_seg = 8'hFF;
   logic        exp_fd = 1'b0;

   seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC), .DIGITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_value  (seg_value),
      .seg_we     (seg_we),
      .enable     (enable),
      .an         (an),
      .seg_n      (seg_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0d, time %0t)", name, act, exp, m_t, $time);
      end
   endtask

   function automatic logic [7:0] model_seg(input logic [31:0] disp, input int d);
      logic [31:0] upper;
      logic [3:0]  nib;
      upper = disp >> (4 * d);
      nib   = upper[3:0];
`ifdef SEG_LZB_EN
      if (d > 0 && upper == 32'd0) return 8'hFF;
`endif
      return DEC[8 * nib +: 8];
   endfunction

   // Model: time t since scan start decides slot, digit and blank/show phase.
   task automatic model_update();
      int pos;
      int d;
      if (rst) begin
         m_pending = 32'd0;
         m_display = 32'd0;
         m_run     = 1'b0;
         m_t       = 0;
      end else begin
         if (!enable) begin
            m_run = 1'b0;
            m_t   = 0;
         end else if (!m_run) begin
            m_run     = 1'b1;
            m_t       = 0;
            m_display = m_pending;
         end else begin
            m_t++;
            if (m_t % FRAME == 0) m_display = m_pending;
         end
         if (seg_we) m_pending = seg_value;
      end
      if (!m_run) begin
         exp_an  = 8'hFF;
         exp_seg = 8'hFF;
         exp_fd  = 1'b0;
      end else begin
         pos     = m_t % CLK_DIV;
         d       = (m_t / CLK_DIV) % 8;
         exp_an  = (pos < BLANK_CYC) ? 8'hFF : ~(8'h01 << d);
         exp_seg = model_seg(m_display, d);
         exp_fd  = (m_t > 0) && (m_t % FRAME == 0);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         model_update();
         chk_en = 1'b1;
      end
   endtask

   task automatic lit(input string name, input logic [7:0] e_an, input logic [7:0] e_seg, input logic e_fd);
      check({name, "_an"}, an, e_an);
      check({name, "_seg_n"}, seg_n, e_seg);
      check({name, "_frame_done"}, {7'd0, frame_done}, {7'd0, e_fd});
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("model_an", an, exp_an);
            check("model_seg_n", seg_n, exp_seg);
            check("model_frame_done", {7'd0, frame_done}, {7'd0, exp_fd});
         end
      end
   end

   initial begin
      // Reset
      run(3);
      lit("reset", 8'hFF, 8'hFF, 1'b0);
      rst = 1'b0;
      run(1);
      lit("idle", 8'hFF, 8'hFF, 1'b0);

      // Enable: digit 0 blank then show, display is 0
      enable = 1'b1;
      run(1);                                   // t=0
      lit("first_blank", 8'hFF, 8'hC0, 1'b0);
      run(2);                                   // t=2
      lit("first_show", 8'hFE, 8'hC0, 1'b0);
      run(8);                                   // t=10
      check("digit1_show_an", an, 8'hFD);

      // Mid-frame write: current frame keeps old value
      seg_value = 32'h7654_3210;
      seg_we    = 1'b1;
      run(1);                                   // t=11
      seg_we    = 1'b0;
      check("midwrite_still_digit1", an, 8'hFD);
      run(53);                                  // t=64
      lit("frame_boundary", 8'hFF, 8'hC0, 1'b1);
      run(1);                                   // t=65
      check("frame_done_one_cycle", {7'd0, frame_done}, 8'd0);
      run(25);                                  // t=90
      lit("new_digit3", 8'hF7, 8'hB0, 1'b0);
      run(32);                                  // t=122
      lit("new_digit7", 8'h7F, 8'hF8, 1'b0);

      // Write on the exact frame-boundary cycle
      run(5);                                   // t=127
      seg_value = 32'hDEAD_BEEF;
      seg_we    = 1'b1;
      run(1);                                   // t=128
      seg_we    = 1'b0;
      check("boundary_fd", {7'd0, frame_done}, 8'd1);
      run(2);                                   // t=130
      lit("boundary_old_value", 8'hFE, 8'hC0, 1'b0);
      run(64);                                  // t=194
      lit("dead_digit0", 8'hFE, 8'h8E, 1'b0);
      run(56);                                  // t=250
      lit("dead_digit7", 8'h7F, 8'hA1, 1'b0);

      // Drop enable mid-show of digit 3 after queuing a new value
      run(32);                                  // t=282
      lit("pre_drop_digit3", 8'hF7, 8'h83, 1'b0);
      seg_value = 32'h0000_0A05;
      seg_we    = 1'b1;
      run(1);                                   // t=283
      seg_we    = 1'b0;
      enable    = 1'b0;
      run(1);
      lit("disabled", 8'hFF, 8'hFF, 1'b0);
      run(3);
      enable = 1'b1;
      run(1);                                   // t=0
      lit("reenable_blank", 8'hFF, 8'h92, 1'b0);
      run(2);                                   // t=2
      lit("a05_digit0", 8'hFE, 8'h92, 1'b0);
      run(8);                                   // t=10
      lit("a05_digit1", 8'hFD, 8'hC0, 1'b0);
      run(8);                                   // t=18
      lit("a05_digit2", 8'hFB, 8'h88, 1'b0);
      run(8);                                   // t=26
`ifdef SEG_LZB_EN
      lit("a05_digit3_lzb", 8'hF7, 8'hFF, 1'b0);
`else
      lit("a05_digit3", 8'hF7, 8'hC0, 1'b0);
`endif

      // Reset mid-show of digit 5 while enabled
      run(17);                                  // t=43
      check("pre_reset_digit5_an", an, 8'hDF);
      rst = 1'b1;
      run(1);
      lit("reset_mid_scan", 8'hFF, 8'hFF, 1'b0);
      rst = 1'b0;
      run(1);                                   // t=0
      lit("after_reset_blank", 8'hFF, 8'hC0, 1'b0);
      run(2);                                   // t=2
      lit("after_reset_digit0", 8'hFE, 8'hC0, 1'b0);
      run(8);                                   // t=10
`ifdef SEG_LZB_EN
      lit("zero_digit1_lzb", 8'hFD, 8'hFF, 1'b0);
`else
      lit("zero_digit1", 8'hFD, 8'hC0, 1'b0);
`endif
      run(70);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit, common-anode 7-segment display.
- Source data is the 32-bit Seg register in the memory-mapped IO block at 0xFFFFF000.
- Double-buffers CPU writes so a frame never tears, sequences anodes with an anti-ghosting blank interval, and decodes each hex nibble to active-low segments.
- Sits between the IO block's Seg output/write strobe and the board pins.

Parameters:
CLK_DIV, 50000, clk cycles per digit slot (BLANK + SHOW); CLK_DIV > BLANK_CYC required
BLANK_CYC, 16, cycles at slot start with all anodes off; >= 1
DIGITS, 8, number of digits scanned; fixed at 8 (nibble i -> digit i)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
seg_value  in  32  value written by CPU to Seg register
seg_we  in  1  one-cycle strobe, high on the cycle the CPU writes Seg
enable  in  1  scan enable; low = display dark
an  out  8  digit anodes, active-low, one-hot-low while showing
seg_n  out  8  cathodes {dp,g,f,e,d,c,b,a}, active-low
frame_done  out  1  one-cycle pulse at end of the last digit's SHOW

Behaviour:
- Reset (clk edge with rst=1):
  - an=8'hFF, seg_n=8'hFF, frame_done=0.
  - pending=0, display=0, digit index=0, slot counter=0, state=IDLE.
  - Reset mid-scan has the same effect: no partial digit survives.
- Buffering:
  - seg_we=1 loads pending<=seg_value (last write wins).
  - display<=pending only on entry to digit 0's BLANK, i.e. frame start or leaving IDLE.
  - A write on the same cycle as that load goes to pending only; the load uses the old pending, so the new value shows next frame.
- State machine; all outputs are registered and change with state:
  - IDLE: an=FF, seg_n=FF. If enable=1, go to BLANK next cycle, with digit=0, counter=0, and display loaded.
  - BLANK: an=FF; seg_n = decode(display nibble[digit]), presetting cathodes. Stay BLANK_CYC cycles, then go to SHOW.
  - SHOW: an=~(1<<digit); seg_n as in BLANK. Stay CLK_DIV-BLANK_CYC cycles.
  - At the end of SHOW:
    - If digit==7: frame_done=1 for 1 cycle (the first BLANK cycle of the next frame), digit wraps to 0, display reloads.
    - Otherwise: digit+1, go to BLANK.
  - enable=0 in any state: IDLE on the next edge, an/seg_n=FF the same edge, digit and counter cleared, frame_done=0.
- Timing:
  - Frame period is exactly 8*CLK_DIV cycles.
  - Each anode is low for CLK_DIV-BLANK_CYC consecutive cycles.
  - Two anodes are never low at once.
- Decode table, hex nibble -> seg_n, dp off (bit7=1):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8
  - 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
- The slot counter is ceil(log2(CLK_DIV)) bits and wraps to 0 at each slot end; no overflow past CLK_DIV-1.

Optional Feature:
- Macro SEG_LZB_EN (leading-zero blanking).
- Defined:
  - Digit i shows blank (seg_n=FF) when all nibbles i..7 of display are 0, for i>=1.
  - Digit 0 is always shown, so display=0 shows a single "0".
  - The anode timing is unchanged.
- Undefined: all 8 digits are always decoded, leading zeros included.

Test Plan:
All scenarios use CLK_DIV=8, BLANK_CYC=2.
1. Reset, then enable=1: cycle 1 an=FF, seg_n=C0; cycles 3-8 an=FE, seg_n=C0. Subsequent digits follow at 8-cycle spacing, and frame_done pulses once every 64 cycles.
2. seg_we with seg_value=32'h76543210 mid-frame: the current frame still shows the old value. Next frame digit0..7 show C0,F9,A4,B0,99,92,82,F8 on an=FE,FD,...,7F.
3. seg_we with 32'hDEADBEEF on the exact frame-boundary cycle: the following frame shows the old value; the frame after shows 8E,86,86,83,A1,88,86,A1 for digits 0-7.
4. Drop enable mid-SHOW of digit 3 → next edge an=FF, seg_n=FF, frame_done=0. Re-enable → restarts at digit 0 BLANK with the latest pending value.
5. Assert rst mid-SHOW of digit 5 while enable=1 → an=FF, seg_n=FF. After release, digit 0 shows C0 (display cleared to 0).
6. SEG_LZB_EN defined, value 32'h00000A05: digits 0-2 show 92,C0,88; digits 3-7 show seg_n=FF with normal anode timing. Value 0: digit 0 shows C0, digits 1-7 show FF.
